uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_PER_BIT, default 10417, meaning clock cycles per UART bit (9600 bps at 100 MHz; 12 for simulation); legal range 2..262143.
REQ-002 clk_s  input  1  system clock; all logic on rising edge.
REQ-003 rst_s  input  1  reset, asynchronous assert, active-high.
REQ-004 iDATA  input  8  byte to transmit; sampled only on an accepted request.
REQ-005 iVALID  input  1  transmit request; accepted when iVALID and oREADY are both high on a clk_s edge.
REQ-006 oREADY  output  1  high only in IDLE state.
REQ-007 oTXD  output  1  serial line, idle high; registered output.
REQ-008 oBUSY  output  1  high in every state except IDLE.
REQ-009 oDONE  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-010 Frame SHALL be 11 bits: start (0), data bits D0..D7 LSB first, bit 9 (parity/fixed bit), stop (1).
REQ-011 FSM states SHALL be IDLE, START, DATA, BIT9, STOP; IDLE->START on accept; START->DATA, DATA->BIT9 after 8th data bit, BIT9->STOP, each after CLK_PER_BIT cycles; STOP->IDLE after CLK_PER_BIT cycles.
REQ-012 On accept at edge t, iDATA SHALL be latched into a shift register, and oTXD SHALL drive the start bit from cycle t+1.
REQ-013 Each bit SHALL be held on oTXD for exactly CLK_PER_BIT cycles; the frame SHALL occupy cycles t+1 to t+11*CLK_PER_BIT.
REQ-014 An 18-bit baud counter SHALL count 0..CLK_PER_BIT-1 and wrap, advancing the bit on wrap; a 3-bit index SHALL select D0..D7.
REQ-015 oDONE SHALL be high only in cycle t+11*CLK_PER_BIT; IDLE and oREADY SHALL follow in cycle t+11*CLK_PER_BIT+1.
REQ-016 Back-to-back: with iVALID held high, the next accept SHALL occur in the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-017 iVALID and iDATA changes while oBUSY is high SHALL be ignored; the in-flight frame SHALL be unaffected, and no request is queued.
REQ-018 In IDLE, oTXD SHALL be 1, and the counters SHALL be held at 0.

Reset
REQ-019 rst_s high SHALL immediately force state IDLE, oTXD=1, oBUSY=0, oREADY=1 (after clk-independent assert), oDONE=0, counters 0, shift register 8'h00.
REQ-020 Reset mid-frame SHALL abort the frame with no oDONE pulse; the first accept after release SHALL start a complete new frame.

Configuration
REQ-021 Macro UART_TX_PARITY_EN defined: bit 9 SHALL be even parity (XOR of D0..D7).
REQ-022 Macro UART_TX_PARITY_EN undefined: bit 9 SHALL be constant 1, and no parity logic SHALL be synthesised.

Verification (CLK_PER_BIT=12, accept at t=0)
REQ-023 The bench SHALL cover each of the following scenarios:
- Send 8'hA5: oTXD = 0,1,0,1,0,0,1,0,1, then bit9 = 0 (PARITY_EN) or 1 (undefined), then 1; each bit lasts 12 cycles. oDONE is high only at cycle 132.
- Send 8'h01 with PARITY_EN: bit9 = 1, occupying cycles 109-120.
- Send 8'h00 then 8'hFF with iVALID held high: the second accept is at cycle 133, and its start bit begins at cycle 134. oTXD is high at cycle 133.
- Send 8'h3C, then pulse iVALID with iDATA=8'hC3 at cycle 50: the frame is still 8'h3C, and oDONE pulses exactly once.
- Assert rst_s during D3 (cycle 50): oTXD=1, oBUSY=0, oREADY=1 before the next clock edge, and no oDONE. After release, send 8'h5A: the full frame is correct.
- Idle for 1000 cycles with no request: oTXD stays 1, and oBUSY and oDONE stay 0.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 11-bit frame UART transmitter (start, D0..D7 LSB first, bit 9, stop).
// Define UART_TX_PARITY_EN to make bit 9 even parity; otherwise bit 9 is a constant 1.
module uart_tx #(
    parameter int CLK_PER_BIT = 10417
) (
    input  logic       clk_s,
    input  logic       rst_s,
    input  logic [7:0] iDATA,
    input  logic       iVALID,
    output logic       oREADY,
    output logic       oTXD,
    output logic       oBUSY,
    output logic       oDONE
);
    typedef enum logic [2:0] {IDLE, START, DATA, BIT9, STOP} state_t;
    localparam logic [17:0] LAST = 18'(CLK_PER_BIT - 1);
    state_t      state_q, state_d;
    logic [17:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic        txd_q, txd_d;
    logic        wrap, bit9;
    assign wrap = cnt_q == LAST;
`ifdef UART_TX_PARITY_EN
    assign bit9 = ^sh_q;
`else
    assign bit9 = 1'b1;
`endif
    assign oREADY = state_q == IDLE;
    assign oBUSY  = state_q != IDLE;
    assign oDONE  = state_q == STOP && wrap;
    assign oTXD   = txd_q;
    // txd_d is the level for the upcoming cycle, so the line stays a pure register output
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || wrap) ? '0 : cnt_q + 18'd1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                txd_d = 1'b1;
                if (iVALID) begin
                    state_d = START;
                    sh_d    = iDATA;
                    txd_d   = 1'b0;
                end
            end
            START: if (wrap) begin
                state_d = DATA;
                txd_d   = sh_q[0];
            end
            DATA: if (wrap) begin
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'd7) ? BIT9 : DATA;
                txd_d   = (idx_q == 3'd7) ? bit9 : sh_q[idx_q + 3'd1];
            end
            BIT9: if (wrap) begin
                state_d = STOP;
                txd_d   = 1'b1;
            end
            STOP: if (wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized checks of uart_tx against a frame-level model.
module tb_uart_tx;
    localparam int CPB = 12;
    localparam int FLEN = 11 * CPB;
`ifdef UART_TX_PARITY_EN
    localparam logic PEN = 1'b1;
`else
    localparam logic PEN = 1'b0;
`endif
    logic clk = 1'b0, rst_s = 1'b1, iVALID = 1'b0;
    logic [7:0] iDATA = 8'h00;
    logic oREADY, oTXD, oBUSY, oDONE;
    logic [3:0] outs;
    int checks = 0, errors = 0;
    localparam logic [3:0] IDLE_O = 4'b1010;
    uart_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk_s(clk), .rst_s(rst_s), .iDATA(iDATA), .iVALID(iVALID),
        .oREADY(oREADY), .oTXD(oTXD), .oBUSY(oBUSY), .oDONE(oDONE)
    );
    assign outs = {oTXD, oBUSY, oREADY, oDONE};
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       hold;
        int         glitch;
        int         rstc;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    // Wire-order frame: bit 0 is the start bit, bit 10 the stop bit.
    function automatic logic [10:0] model(input logic [7:0] d);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = d[i];
            ones += int'(d[i]);
        end
        f[9] = PEN ? logic'(ones % 2) : 1'b1;
        f[10] = 1'b1;
        return f;
    endfunction
    task automatic run_frame(input logic [10:0] fr, input logic [7:0] d, input logic hold,
                             input logic [7:0] nd, input int glitch, input int rstc, input logic noise);
        int dn = 0;
        chk("ready_pre", 32'(outs), 32'(IDLE_O));
        iVALID = 1'b1;
        iDATA = d;
        @(posedge clk);
        for (int c = 1; c <= FLEN; c++) begin
            @(negedge clk);
            chk($sformatf("frame_%02h_c%0d", d, c), 32'(outs),
                32'({fr[(c - 1) / CPB], 1'b1, 1'b0, c == FLEN}));
            dn += int'(oDONE);
            if (c == 1) begin
                iVALID = hold;
                iDATA = hold ? nd : d;
            end
            if (noise) begin
                iVALID = 1'($urandom);
                iDATA = 8'($urandom);
            end
            if (glitch > 0 && c == glitch) begin
                iVALID = 1'b1;
                iDATA = 8'hC3;
            end
            if (glitch > 0 && c == glitch + 1) iVALID = hold;
            if (c == rstc) begin
                iVALID = 1'b0;
                rst_s = 1'b1;
                #1;
                chk("rst_async", 32'(outs), 32'(IDLE_O));
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_hold", 32'(outs), 32'(IDLE_O));
                    dn += int'(oDONE);
                end
                rst_s = 1'b0;
                @(negedge clk);
                chk("rst_release", 32'(outs), 32'(IDLE_O));
                chk("rst_no_done", dn, 0);
                return;
            end
        end
        @(negedge clk);
        chk($sformatf("post_%02h", d), 32'(outs), 32'(IDLE_O));
        chk($sformatf("done_count_%02h", d), dn, 1);
        if (!hold) iVALID = 1'b0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [7:0] rd;
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{8'h01, 1'b1, 1'b0, 0, 0};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 0, 0};
        tbl[3] = '{8'hFF, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 50, 0};
        tbl[5] = '{8'h3C, 1'b0, 1'b0, 0, 50};
        tbl[6] = '{8'h5A, 1'b0, 1'b0, 0, 0};
        tbl[7] = '{8'h80, 1'b1, 1'b0, 0, 0};
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(outs), 32'(IDLE_O));
        rst_s = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(outs), 32'(IDLE_O));
        for (int i = 0; i < 8; i++)
            run_frame({1'b1, PEN ? tbl[i].par : 1'b1, tbl[i].d, 1'b0}, tbl[i].d, tbl[i].hold,
                      (i < 7) ? tbl[i + 1].d : 8'h00, tbl[i].glitch, tbl[i].rstc, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle_long", 32'(outs), 32'(IDLE_O));
        end
        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom);
            run_frame(model(rd), rd, 1'b0, 8'h00, 0, 0, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("rand_gap", 32'(outs), 32'(IDLE_O));
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
